// File: rtl/multiplier_pkg.sv
// rtl/multiplier_pkg.sv - shared widths and record types for the Montgomery reduction datapath
package multiplier_pkg;

  localparam int DATA_LENGTH = 16;
  localparam int MBL_WIDTH   = $clog2(DATA_LENGTH) + 1;

  typedef struct packed {
    logic [DATA_LENGTH-1:0] m;
    logic [MBL_WIDTH-1:0]   m_bl;
    logic [DATA_LENGTH-1:0] minv;
  } redc_ctx_t;

  // qs holds q in the first stage and the full-width sum in the second
  typedef struct packed {
    logic                     v;
    logic [2*DATA_LENGTH-1:0] x;
    logic [2*DATA_LENGTH:0]   qs;
  } redc_stage_t;

endpackage

// File: rtl/montgomery_redc_stage3.sv
// rtl/montgomery_redc_stage3.sv - REDC final step: shift by m_bl, compare and conditional subtract
module montgomery_redc_stage3
  import multiplier_pkg::*;
#(
  parameter int W   = DATA_LENGTH,
  parameter int BLW = $clog2(W) + 1
) (
  input  logic [2*W:0]   sum_i,
  input  logic [BLW-1:0] m_bl_i,
  input  logic [W-1:0]   m_i,
  output logic [W-1:0]   res_o
);

  // For legal operands t < 2m, so W+1 bits hold it without loss
  logic [W:0] t;

  assign t     = (W+1)'(sum_i >> m_bl_i);
  assign res_o = (t >= {1'b0, m_i}) ? W'(t - {1'b0, m_i}) : t[W-1:0];

endmodule

// File: rtl/montgomery_redc_pipe.sv
// rtl/montgomery_redc_pipe.sv - three-stage streaming Montgomery reduction with loadable modulus context
module montgomery_redc_pipe
  import multiplier_pkg::*;
#(
  parameter int ID_WIDTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  output logic                     cfg_ready_o,
  input  logic [DATA_LENGTH-1:0]   cfg_m_i,
  input  logic [MBL_WIDTH-1:0]     cfg_m_bl_i,
  input  logic [DATA_LENGTH-1:0]   cfg_minv_i,
  output logic                     cfg_err_o,
  input  logic                     in_valid_i,
  output logic                     in_ready_o,
  input  logic [2*DATA_LENGTH-1:0] in_x_i,
  input  logic [ID_WIDTH-1:0]      in_id_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_LENGTH-1:0]   out_res_o,
  output logic [ID_WIDTH-1:0]      out_id_o
);

  localparam int W = DATA_LENGTH;

  redc_ctx_t            ctx_q;
  redc_stage_t          s1_q, s2_q;
  logic [ID_WIDTH-1:0]  id1_q, id2_q, out_id_q;
  logic                 s3_v_q, cfg_err_q;
  logic [W-1:0]         res_q;

  logic                 stall, cfg_load, cfg_bad, accept;
  logic [MBL_WIDTH-1:0] mask_sh;
  logic [W-1:0]         mask_r, q_d, res_d;
  logic [2*W:0]         sum_d;
  logic                 unused_s2_x;

  assign stall       = s3_v_q & ~out_ready_i;
  assign cfg_ready_o = ~(s1_q.v | s2_q.v | s3_v_q);
  assign cfg_load    = cfg_valid_i & cfg_ready_o;
  assign in_ready_o  = ~stall & ~cfg_load;
  assign accept      = in_valid_i & in_ready_o;
  assign cfg_bad     = (cfg_m_bl_i == '0) || (cfg_m_bl_i > MBL_WIDTH'(W));

  // Shifting an all-ones word avoids the 1<<W overflow when m_bl == W
  assign mask_sh = MBL_WIDTH'(W) - ctx_q.m_bl;
  assign mask_r  = {W{1'b1}} >> mask_sh;
  assign q_d     = ((in_x_i[W-1:0] & mask_r) * ctx_q.minv) & mask_r;
  assign sum_d   = {1'b0, s1_q.x} + s1_q.qs * (2*W+1)'(ctx_q.m);

  assign unused_s2_x = ^s2_q.x;

  montgomery_redc_stage3 #(.W(W), .BLW(MBL_WIDTH)) u_stage3 (
    .sum_i  (s2_q.qs),
    .m_bl_i (ctx_q.m_bl),
    .m_i    (ctx_q.m),
    .res_o  (res_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctx_q     <= '0;
      s1_q      <= '0;
      s2_q      <= '0;
      id1_q     <= '0;
      id2_q     <= '0;
      s3_v_q    <= 1'b0;
      res_q     <= '0;
      out_id_q  <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_load & cfg_bad;
      if (cfg_load && !cfg_bad) begin
        ctx_q <= '{m: cfg_m_i, m_bl: cfg_m_bl_i, minv: cfg_minv_i};
      end
      // The context can only change while the pipe is empty, so every stage sees a stable one
      if (!stall) begin
        s1_q.v <= accept;
        if (accept) begin
          s1_q.x  <= in_x_i;
          s1_q.qs <= (2*W+1)'(q_d);
          id1_q   <= in_id_i;
        end
        s2_q.v   <= s1_q.v;
        s2_q.x   <= s1_q.x;
        s2_q.qs  <= sum_d;
        id2_q    <= id1_q;
        s3_v_q   <= s2_q.v;
        res_q    <= res_d;
        out_id_q <= id2_q;
      end
    end
  end

  assign out_valid_o = s3_v_q;
  assign out_res_o   = res_q;
  assign out_id_o    = out_id_q;
  assign cfg_err_o   = cfg_err_q;

endmodule

// File: tb/tb_montgomery_redc_pipe.sv
// tb/tb_montgomery_redc_pipe.sv - self-checking bench for montgomery_redc_pipe
module tb_montgomery_redc_pipe;
  import multiplier_pkg::*;

  localparam int W   = DATA_LENGTH;
  localparam int BLW = MBL_WIDTH;
  localparam int IDW = 4;

  logic             clk, rst_ni;
  logic             cfg_valid, cfg_ready, cfg_err;
  logic [W-1:0]     cfg_m, cfg_minv;
  logic [BLW-1:0]   cfg_m_bl;
  logic             in_valid, in_ready, out_valid, out_ready;
  logic [2*W-1:0]   in_x;
  logic [IDW-1:0]   in_id, out_id;
  logic [W-1:0]     out_res;

  int checks = 0;
  int failures = 0;

  logic [W-1:0]     cur_m;
  int               cur_mbl;

  logic [2*W-1:0]   drv_x[$];
  logic [IDW-1:0]   drv_id[$];
  logic [W-1:0]     got_res[$];
  logic [IDW-1:0]   got_id[$];

  montgomery_redc_pipe #(.ID_WIDTH(IDW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .cfg_valid_i (cfg_valid),
    .cfg_ready_o (cfg_ready),
    .cfg_m_i     (cfg_m),
    .cfg_m_bl_i  (cfg_m_bl),
    .cfg_minv_i  (cfg_minv),
    .cfg_err_o   (cfg_err),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_x_i      (in_x),
    .in_id_i     (in_id),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_res_o   (out_res),
    .out_id_o    (out_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // x * R^-1 mod m, with R^-1 built from repeated halving mod m (m odd)
  function automatic logic [W-1:0] ref_redc(input logic [2*W-1:0] x, input logic [W-1:0] m, input int mbl);
    longint unsigned mm, rinv, inv2, xr;
    mm = longint'(m);
    inv2 = (mm + 1) / 2;
    rinv = 1;
    for (int i = 0; i < mbl; i++) rinv = (rinv * inv2) % mm;
    xr = longint'(x) % mm;
    return W'((xr * rinv) % mm);
  endfunction

  task automatic cycle(input logic iv, input logic [2*W-1:0] x, input logic [IDW-1:0] id, input logic ordy,
                       output logic acc, output logic ofire, output logic [W-1:0] ores, output logic [IDW-1:0] oid);
    in_valid = iv; in_x = x; in_id = id; out_ready = ordy;
    #1;
    acc = in_valid & in_ready;
    ofire = out_valid & ordy;
    ores = out_res;
    oid = out_id;
    @(posedge clk); #1;
  endtask

  task automatic load_cfg(input logic [W-1:0] m, input int mbl, input logic [W-1:0] minv);
    in_valid = 1'b0; out_ready = 1'b1;
    cfg_valid = 1'b1; cfg_m = m; cfg_m_bl = BLW'(mbl); cfg_minv = minv;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  // mode 0: out_ready high; 1: out_ready low in cycles 3..6; 2: random valid/ready gaps
  task automatic drive_stream(input int mode, output int stable_err, output int stall_cycles,
                              output int extra, output bit timeout);
    int idx, cyc, limit;
    logic pstall;
    logic [W-1:0] pres;
    logic [IDW-1:0] pid;
    logic ordy;
    idx = 0; cyc = 0; pstall = 0; pres = '0; pid = '0;
    limit = 4 * drv_x.size() + 50;
    got_res.delete(); got_id.delete();
    stable_err = 0; stall_cycles = 0; extra = 0; timeout = 0;
    while (idx < drv_x.size() || got_res.size() < drv_x.size()) begin
      if (cyc >= limit) begin
        timeout = 1;
        break;
      end
      in_valid = 1'b0; in_x = '0; in_id = '0;
      if (idx < drv_x.size() && (mode != 2 || $urandom_range(9) != 0)) begin
        in_valid = 1'b1; in_x = drv_x[idx]; in_id = drv_id[idx];
      end
      case (mode)
        1:       ordy = !(cyc >= 3 && cyc <= 6);
        2:       ordy = ($urandom_range(9) >= 3);
        default: ordy = 1'b1;
      endcase
      out_ready = ordy;
      #1;
      if (pstall && !(out_valid && out_res == pres && out_id == pid)) stable_err++;
      pstall = out_valid & ~ordy;
      pres = out_res; pid = out_id;
      if (pstall) stall_cycles++;
      if (in_valid && in_ready) idx++;
      if (out_valid && ordy) begin
        got_res.push_back(out_res);
        got_id.push_back(out_id);
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (out_valid) extra++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; cfg_valid = 1'b0; cfg_m = '0; cfg_m_bl = '0; cfg_minv = '0;
    in_valid = 1'b0; in_x = '0; in_id = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_res !== '0) begin failures++; $display("FAIL reset_out_res got=%0d exp=0", out_res); end
    checks++; if (out_id !== '0) begin failures++; $display("FAIL reset_out_id got=%0d exp=0", out_id); end
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    checks++; if (cfg_ready !== 1'b1) begin failures++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready); end
    rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    logic acc, fire;
    logic [W-1:0] r;
    logic [IDW-1:0] id;
    int n;
    load_cfg(17, 5, 15);
    cur_m = 17; cur_mbl = 5;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL good_cfg_err got=%b exp=0", cfg_err); end
    cycle(1'b1, 100, 3, 1'b1, acc, fire, r, id);
    checks++; if (acc !== 1'b1) begin failures++; $display("FAIL single_accept got=%b exp=1", acc); end
    n = 0;
    for (int k = 1; k <= 10; k++) begin
      cycle(1'b0, '0, '0, 1'b1, acc, fire, r, id);
      if (fire) begin
        n = k;
        break;
      end
    end
    checks++; if (n != 3) begin failures++; $display("FAIL single_latency got=%0d exp=3", n); end
    checks++; if (r !== ref_redc(100, cur_m, cur_mbl)) begin failures++; $display("FAIL single_res got=%0d exp=%0d", r, ref_redc(100, cur_m, cur_mbl)); end
    checks++; if (id !== 4'd3) begin failures++; $display("FAIL single_id got=%0d exp=3", id); end
  endtask

  task automatic test_boundary();
    int se, sc, ex;
    bit to;
    drv_x = '{0, 543}; drv_id = '{5, 6};
    drive_stream(0, se, sc, ex, to);
    checks++; if (to || got_res.size() != 2) begin failures++; $display("FAIL boundary_count got=%0d exp=2 timeout=%0d", got_res.size(), to); end
    for (int i = 0; i < got_res.size() && i < 2; i++) begin
      checks++;
      if (got_res[i] !== ref_redc(drv_x[i], cur_m, cur_mbl) || got_id[i] !== drv_id[i]) begin
        failures++;
        $display("FAIL boundary_res[%0d] got=%0d/id%0d exp=%0d/id%0d", i, got_res[i], got_id[i], ref_redc(drv_x[i], cur_m, cur_mbl), drv_id[i]);
      end
    end
  endtask

  task automatic test_back_to_back_stall();
    int se, sc, ex;
    bit to;
    drv_x = '{100, 543, 0}; drv_id = '{1, 2, 3};
    drive_stream(1, se, sc, ex, to);
    checks++; if (to || got_res.size() != 3) begin failures++; $display("FAIL stall_count got=%0d exp=3 timeout=%0d", got_res.size(), to); end
    for (int i = 0; i < got_res.size() && i < 3; i++) begin
      checks++;
      if (got_res[i] !== ref_redc(drv_x[i], cur_m, cur_mbl) || got_id[i] !== drv_id[i]) begin
        failures++;
        $display("FAIL stall_res[%0d] got=%0d/id%0d exp=%0d/id%0d", i, got_res[i], got_id[i], ref_redc(drv_x[i], cur_m, cur_mbl), drv_id[i]);
      end
    end
    checks++; if (sc != 4) begin failures++; $display("FAIL stall_cycles got=%0d exp=4", sc); end
    checks++; if (se != 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", se); end
    checks++; if (ex != 0) begin failures++; $display("FAIL stall_dup got=%0d exp=0", ex); end
  endtask

  task automatic test_cfg_busy();
    logic acc, fire;
    logic [W-1:0] r;
    logic [IDW-1:0] id;
    int nacc, busy, seen, se, sc, ex;
    bit ok, to;
    nacc = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2*W'(i * 50), IDW'(i), 1'b0, acc, fire, r, id);
      if (acc) nacc++;
    end
    checks++; if (nacc != 3) begin failures++; $display("FAIL cfg_fill got=%0d exp=3", nacc); end
    in_valid = 1'b0;
    cfg_valid = 1'b1; cfg_m = 99; cfg_m_bl = '0; cfg_minv = 7;
    busy = 0;
    for (int k = 0; k < 4; k++) begin
      out_ready = 1'b0;
      #1;
      if (cfg_ready === 1'b0) busy++;
      @(posedge clk); #1;
    end
    checks++; if (busy != 4) begin failures++; $display("FAIL cfg_ready_busy got=%0d exp=4", busy); end
    out_ready = 1'b1; seen = 0; ok = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (cfg_ready) begin
        ok = 1;
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cfg_priority in_ready got=%b exp=0", in_ready); end
        break;
      end
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    checks++; if (!ok || seen != 3) begin failures++; $display("FAIL cfg_drain ready=%0d outputs got=%0d exp=3", ok, seen); end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    checks++; if (cfg_err !== 1'b1) begin failures++; $display("FAIL cfg_err_pulse got=%b exp=1", cfg_err); end
    @(posedge clk); #1;
    checks++; if (cfg_err !== 1'b0) begin failures++; $display("FAIL cfg_err_clear got=%b exp=0", cfg_err); end
    drv_x = '{100}; drv_id = '{9};
    drive_stream(0, se, sc, ex, to);
    checks++;
    if (to || got_res.size() != 1 || got_res[0] !== ref_redc(100, cur_m, cur_mbl)) begin
      failures++;
      $display("FAIL cfg_ctx_kept count=%0d got=%0d exp=%0d", got_res.size(), (got_res.size() > 0) ? got_res[0] : '0, ref_redc(100, cur_m, cur_mbl));
    end
  endtask

  task automatic test_random_full_width();
    int se, sc, ex, bad;
    bit to;
    logic [W-1:0] e;
    load_cfg(16'hFFFF, W, 1);
    cur_m = 16'hFFFF; cur_mbl = W;
    drv_x.delete(); drv_id.delete();
    drv_x.push_back('0); drv_id.push_back(0);
    drv_x.push_back(32'hFFFE_FFFF); drv_id.push_back(1);
    for (int i = 2; i < 10000; i++) begin
      drv_x.push_back($urandom % 32'hFFFF_0000);
      drv_id.push_back(IDW'($urandom));
    end
    drive_stream(2, se, sc, ex, to);
    checks++; if (to || got_res.size() != drv_x.size()) begin failures++; $display("FAIL rand_count got=%0d exp=%0d timeout=%0d", got_res.size(), drv_x.size(), to); end
    bad = 0;
    for (int i = 0; i < got_res.size() && i < drv_x.size(); i++) begin
      e = ref_redc(drv_x[i], cur_m, cur_mbl);
      checks++;
      if (got_res[i] !== e || got_id[i] !== drv_id[i]) begin
        failures++;
        $display("FAIL rand_res[%0d] x=%0h got=%0d/id%0d exp=%0d/id%0d", i, drv_x[i], got_res[i], got_id[i], e, drv_id[i]);
      end
    end
    checks++; if (se != 0) begin failures++; $display("FAIL rand_stable got=%0d exp=0", se); end
    checks++; if (ex != 0) begin failures++; $display("FAIL rand_dup got=%0d exp=0", ex); end
  endtask

  task automatic test_reset_inflight();
    logic acc, fire;
    logic [W-1:0] r;
    logic [IDW-1:0] id;
    int viol;
    for (int i = 0; i < 3; i++) cycle(1'b1, 2*W'($urandom), IDW'(i), 1'b0, acc, fire, r, id);
    rst_ni = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_async out_valid got=%b exp=0", out_valid); end
    @(posedge clk); @(posedge clk); #1;
    rst_ni = 1'b1;
    viol = 0;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid !== 1'b0 || cfg_ready !== 1'b1) viol++;
      @(posedge clk); #1;
    end
    checks++; if (viol != 0) begin failures++; $display("FAIL rst_inflight violations got=%0d exp=0", viol); end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back_stall();
    test_cfg_busy();
    test_random_full_width();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
